// File: rtl/nf10_axis_downsizer_pkg.sv
// Shared widths and helpers for the 256->64 AXI4-Stream downsizer.
package nf10_axis_downsizer_pkg;

    localparam int DEFAULT_M_DATA_WIDTH = 64;
    localparam int DEFAULT_S_DATA_WIDTH = 256;
    localparam int DEFAULT_TUSER_WIDTH  = 128;

    function automatic int width_ratio(input int s_width, input int m_width);
        return s_width / m_width;
    endfunction

    // A single-lane configuration still needs a 1-bit lane index to stay legal.
    function automatic int lane_index_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int RATIO       = width_ratio(DEFAULT_S_DATA_WIDTH, DEFAULT_M_DATA_WIDTH);
    localparam int LANE_IDX_W  = lane_index_width(RATIO);
    localparam int LANE_STRB_W = DEFAULT_M_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/nf10_axis_last_lane.sv
// Final-lane finder: highest lane with any strobe set on a last word,
// lane 0 when a last word has no strobes, the top lane otherwise.
module nf10_axis_last_lane
    import nf10_axis_downsizer_pkg::*;
#(
    parameter int R           = RATIO,
    parameter int LANE_W      = LANE_IDX_W,
    parameter int LANE_STRB_W = nf10_axis_downsizer_pkg::LANE_STRB_W
) (
    input  logic [R*LANE_STRB_W-1:0] strb,
    input  logic                     last,
    output logic [LANE_W-1:0]        final_lane
);

    // Scan lanes upward so the highest populated lane wins.
    always_comb begin
        final_lane = '0;
        if (!last) begin
            final_lane = LANE_W'(R - 1);
        end else begin
            for (int l = 0; l < R; l++) begin
                if (|strb[l*LANE_STRB_W +: LANE_STRB_W]) begin
                    final_lane = LANE_W'(l);
                end
            end
        end
    end

endmodule

// File: rtl/nf10_axis_downsizer.sv
// Narrows a wide AXI4-Stream packet stream into low-lane-first narrow beats.
// One holding register plus a lane counter; the last word of a packet is
// trimmed to its populated lanes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | holding register empty, input always ready
// ST_EMIT  | holding register full, driving lane `lane` of the held word
module nf10_axis_downsizer
    import nf10_axis_downsizer_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = DEFAULT_M_DATA_WIDTH,
    parameter int C_S_AXIS_DATA_WIDTH  = DEFAULT_S_DATA_WIDTH,
    parameter int C_M_AXIS_TUSER_WIDTH = DEFAULT_TUSER_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = DEFAULT_TUSER_WIDTH
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int R      = width_ratio(C_S_AXIS_DATA_WIDTH, C_M_AXIS_DATA_WIDTH);
    localparam int LANE_W = lane_index_width(R);
    localparam int SW     = C_M_AXIS_DATA_WIDTH / 8;

    state_t                             state;
    state_t                             state_next;
    logic [LANE_W-1:0]                  lane;
    logic [LANE_W-1:0]                  final_lane;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     held_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   held_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    held_user;
    logic                               held_last;
    logic                               full;
    logic                               at_final;
    logic                               in_hs;
    logic                               out_hs;
    logic                               retire;

    nf10_axis_last_lane #(
        .R           (R),
        .LANE_W      (LANE_W),
        .LANE_STRB_W (SW)
    ) u_last_lane (
        .strb       (held_strb),
        .last       (held_last),
        .final_lane (final_lane)
    );

    assign full     = (state == ST_EMIT);
    assign at_final = (lane == final_lane);
    assign out_hs   = full && m_axis_tready;
    assign retire   = out_hs && at_final;

    // Ready whenever the held word is absent or leaves this cycle, so a new
    // word can replace the retiring one without a bubble.
    assign s_axis_tready = !full || (m_axis_tready && at_final);
    assign in_hs         = s_axis_tvalid && s_axis_tready;

    // State register; reset discards any held word immediately.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a load always wins over retirement.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_hs) state_next = ST_EMIT;
            ST_EMIT: begin
                if (in_hs) begin
                    state_next = ST_EMIT;
                end else if (retire) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Holding register and lane counter.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            held_data <= '0;
            held_strb <= '0;
            held_user <= '0;
            held_last <= 1'b0;
            lane      <= '0;
        end else if (in_hs) begin
            held_data <= s_axis_tdata;
            held_strb <= s_axis_tstrb;
            held_user <= s_axis_tuser;
            held_last <= s_axis_tlast;
            lane      <= '0;
        end else if (out_hs && !at_final) begin
            lane <= lane + 1'b1;
        end else if (retire) begin
            lane <= '0;
        end
    end

    // Output beat: selected lane of the held word, tuser repeated on every beat.
    always_comb begin
        m_axis_tvalid = full;
        m_axis_tdata  = held_data[int'(lane)*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
        m_axis_tstrb  = held_strb[int'(lane)*SW +: SW];
        m_axis_tuser  = held_user;
        m_axis_tlast  = full && held_last && at_final;
    end

endmodule

// File: doc/nf10_axis_downsizer.md
# nf10_axis_downsizer

Narrows a 256-bit AXI4-Stream packet stream to 64 bits, the reverse of the 64→256 upsizing converter on the receive side. Sits between the 256-bit datapath (output port lookup / output queues) and the 64-bit 10G MAC transmit interfaces. Each accepted wide word is unpacked into up to four narrow beats, low lane first. The final beat of a packet is trimmed to its populated lanes.

## Interface
- C_M_AXIS_DATA_WIDTH, 64, narrow output data width.
- C_S_AXIS_DATA_WIDTH, 256, wide input data width; must be a power-of-two multiple of the output width (ratio R = 4 by default).
- C_M_AXIS_TUSER_WIDTH, 128, output sideband width.
- C_S_AXIS_TUSER_WIDTH, 128, input sideband width; must equal the output width.

Ports:
- axi_aclk  in  1  sole clock.
- axi_resetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  256  wide data, byte 0 in bits [7:0].
- s_axis_tstrb  in  32  byte strobes; contiguous from bit 0.
- s_axis_tuser  in  128  packet metadata (len/src/dst port).
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata  out  64  narrow data.
- m_axis_tstrb  out  8  narrow strobes.
- m_axis_tuser  out  128  metadata.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of packet.

## Operation
- One holding register stores tdata, tstrb, tuser and tlast of one wide word, plus a full flag and lane index `lane` (0..R-1).
- States:
  - EMPTY: full=0.
  - EMIT: full=1; drives lane `lane` of the held word.
- Output beat fields:
  - m_axis_tdata = held data bits [64·lane+63 : 64·lane].
  - m_axis_tstrb = corresponding 8 strobe bits.
  - m_axis_tuser = held tuser; every beat of a word carries the same tuser.
- Final lane F of a held word:
  - If held tlast = 1: the highest lane with any strobe bit set. If no strobe bit is set, F = 0.
  - If held tlast = 0: F = R-1.
- m_axis_tlast = held tlast AND (lane == F).
- On an output handshake (m_axis_tvalid & m_axis_tready):
  - If lane < F: lane increments.
  - If lane == F: the word is retired.
- Lanes above F are never emitted.
- Non-last input words are expected fully strobed. Their lanes are emitted unconditionally, even if the strobes are partial.
- A zero-strobe last word emits exactly one beat (tstrb 8'h00, tlast 1). tlast is never dropped.
- s_axis_tready = !full OR (m_axis_tready AND lane == F).
- Input handshake:
  - Loads the holding register and sets lane to 0.
  - If it coincides with retirement (lane == F with m_axis_tready), load takes priority: full stays 1 and there is no bubble.
- tuser is not modified; the length field stays the byte count of the whole packet.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tstrb 0, m_axis_tuser 0, s_axis_tready 1, full 0, lane 0.
- Latency: a word accepted at edge N produces its first beat with m_axis_tvalid = 1 after edge N.
- Throughput:
  - Sustained one output beat per cycle across word and packet boundaries when m_axis_tready = 1.
  - One input word per (F+1) cycles.
- m_axis_tvalid = full. Once asserted, it is held and the beat stays stable until the handshake (AXI rule).
- s_axis_tready depends combinationally on m_axis_tready. This is the only input-to-output combinational path.
- Reset asserted mid-packet:
  - The held word is discarded immediately and asynchronously.
  - The partial packet is not completed.
  - Outputs return to reset values.

## Structure
- Shared package/header holds:
  - the width ratio R = C_S_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH;
  - the lane-index width log2(R);
  - the strobe-per-lane width C_M_AXIS_DATA_WIDTH/8.
- One natural sub-module: nf10_axis_last_lane. Combinational. Maps wide tstrb + tlast to F (highest populated lane, 0 if none, R-1 if not last).
- Top block: holding register, lane counter, handshake logic.

## Test plan
- Single 64-byte packet: two words, tstrb 32'hFFFFFFFF, second with tlast; m_axis_tready = 1. Expect 8 consecutive beats, tstrb 8'hFF, tlast only on beat 8, data in ascending lane order.
- 60-byte packet: last word tstrb 32'h0FFFFFFF. Expect 4 + 4 beats; final beat tstrb 8'h0F with tlast.
- 33-byte packet: last word tstrb 32'h00000001. Expect 4 + 1 beats; last beat tstrb 8'h01, tlast; lanes 1–3 of that word not emitted.
- Back-to-back packets, continuous input and output ready. Expect no idle cycle between tlast of packet A and the first beat of packet B, and tuser switching exactly at the boundary.
- Random m_axis_tready throttling (50%) over 1000 packets of 60–1514 bytes. Expect byte stream, strobes, tlast and tuser to match the scoreboard, and no beat changing while stalled.
- axi_resetn pulsed low during beat 2 of a 4-beat word. Expect m_axis_tvalid = 0 immediately and s_axis_tready = 1. Expect the next packet after reset to be emitted from lane 0 without stale data.
